alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 16-bit ALU. Keeps the same 8-bit opcode map.
- Adds registered result and flag (PSR) outputs, a start/busy/done handshake, and multi-bit shifts (1 bit per cycle). An iterative multiply is optional.
- Sits between the register file and the PSR/writeback stage of the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4, power of 2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
- start  in  1  launch an operation; sampled only when busy=0.
- op  in  8  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B / shift control.
- cin  in  1  carry-in for ADD/ADDU.
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse: result and flags are valid/updated.
- result  out  WIDTH  registered result.
- carry, low, ovf, zero, neg  out  1 each  registered flags (PSR bits C, L, F, Z, N).

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy=0; done=0; result=0; all flags=0. Reset aborts any in-flight op, and no done pulse is issued for it.
- Operands and op are captured at start. Changes to a, b or op while busy are ignored.
- FSM has three states:
  - IDLE: start=1 with a single-cycle op → result/flags written at the next edge, done=1 for that cycle, stay IDLE (latency 1). start with a shift, amount≠0 → SHIFT, busy=1. start with MUL → MUL, busy=1.
  - SHIFT: one bit per cycle; counter loaded with the amount, decremented each cycle. At count 1 → write result/flags, done=1, → IDLE. Total latency is amount+1 cycles.
  - MUL: shift-add, WIDTH iterations, then write, done=1, → IDLE. Latency WIDTH+1.
- busy is deasserted in the same cycle done pulses. start in that cycle, or any cycle with busy=0, is accepted, giving back-to-back issue.
- Opcodes and flag rules (unlisted flags →0; Z = result==0 unless stated):
  - ADD 0x05: {c,r} = a+b+cin. C = carry out. F = signed overflow (operand signs equal, result sign differs). N = r[MSB].
  - ADDU 0x06: as ADD; F=0, N=0.
  - SUB 0x09: r = a−b. C = borrow (a<b unsigned). F = signed overflow (operand signs differ, result sign differs from a). N = r[MSB].
  - CMP 0x0C: result holds. Z = (a==b). N = (b<a) signed.
  - CMPU 0x0B: result holds. Z = (a==b). L = (b<a) unsigned.
  - AND 0x01, OR 0x02, XOR 0x03: bitwise; Z only. NOT 0x0E: r = ~a; Z only.
  - MOV 0x0D: r = b; flags hold.
  - NOP 0x00 and any undefined opcode: result and flags hold. Still a 1-cycle op with a done pulse.
  - LSH 0x84: b[WIDTH−1]=0 → logical left by b[SHW−1:0]. b[WIDTH−1]=1 → logical right by (−b)[SHW−1:0]. C = last bit shifted out. Z updated.
  - ASH 0x86: as LSH, but a right shift replicates the MSB (arithmetic). N = r[MSB].
  - Shift amount 0 (b=0, or −b has zero low bits): completes in 1 cycle, r = a, C=0.
  - MUL 0x0F: low WIDTH bits of unsigned a×b. C = 1 if the high half is non-zero. Z updated.
- Flag registers and result change only on a done cycle.

Optional Feature:
- ALU_MUL_EN defined: MUL opcode 0x0F implemented as above, with MUL state and WIDTH-bit multiplicand/accumulator registers.
- Not defined: 0x0F decodes as undefined (NOP behaviour, 1-cycle done, result/flags hold). No MUL state or registers synthesised.

Test Plan:
- Reset then ADD, WIDTH=16: a=0x7FFF, b=0x0001, cin=0 → 1 cycle later done=1, result=0x8000, ovf=1, neg=1, carry=0, zero=0.
- SUB a=0x0003 b=0x0005 → result=0xFFFE, carry=1, neg=1; then CMPU a=0x0005 b=0x0003 → low=1, zero=0, result stays 0xFFFE.
- ASH a=0x8010, b=0xFFFC (right 4) → busy for 4 cycles, done on the 5th, result=0xF801, carry=0. LSH a=0x8001, b=0x0001 → result=0x0002, carry=1.
- Start a LSH by 8, assert rst_n=0 on the 3rd busy cycle → no done pulse, busy=0, result=0, all flags 0 next cycle.
- Back-to-back: done of a shift coincident with start of AND a=0x00F0 b=0x0F00 → AND accepted; next cycle result=0x0000, zero=1. start pulses while busy are ignored.
- With ALU_MUL_EN: MUL a=0x0100 b=0x0101 → done after 17 cycles, result=0x0100, carry=1. Without ALU_MUL_EN: same stimulus → done after 1 cycle, result/flags unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, sequential successor to the combinational 16-bit ALU.
// Same 8-bit opcode map; adds registered result/PSR flags, a start/busy/done
// handshake and 1-bit-per-cycle multi-bit shifts.
// Optional feature macro: ALU_MUL_EN (iterative shift-add unsigned multiply).
module alu_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             low,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   // counter must hold WIDTH (multiply iterations) as well as shift amounts
   localparam int unsigned CW = SHW + 1;

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_ADDU = 8'h06;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_CMPU = 8'h0B;
   localparam logic [7:0] OP_CMP  = 8'h0C;
   localparam logic [7:0] OP_MOV  = 8'h0D;
   localparam logic [7:0] OP_NOT  = 8'h0E;
   localparam logic [7:0] OP_LSH  = 8'h84;
   localparam logic [7:0] OP_ASH  = 8'h86;
`ifdef ALU_MUL_EN
   localparam logic [7:0] OP_MUL  = 8'h0F;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef ALU_MUL_EN
      ,
      S_MUL   = 2'd2
`endif
   } state_t;

   state_t           state, state_nxt;
   logic             busy_nxt, done_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic             carry_nxt, low_nxt, ovf_nxt, zero_nxt, neg_nxt;

   // shift work register (also the multiplier / low product half when MUL is built)
   logic [WIDTH-1:0] wrk, wrk_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             sh_right, sh_right_nxt;
   logic             sh_arith, sh_arith_nxt;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] mcand, mcand_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH:0]   mac;
`endif

   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] sh_val;
   logic             sh_bit;

   // next-state, datapath and output-register update logic
   always_comb begin
      state_nxt    = state;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      result_nxt   = result;
      carry_nxt    = carry;
      low_nxt      = low;
      ovf_nxt      = ovf;
      zero_nxt     = zero;
      neg_nxt      = neg;
      wrk_nxt      = wrk;
      cnt_nxt      = cnt;
      sh_right_nxt = sh_right;
      sh_arith_nxt = sh_arith;
`ifdef ALU_MUL_EN
      mcand_nxt    = mcand;
      acc_nxt      = acc;
      mac          = {1'b0, acc} + (wrk[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`endif
      sum          = '0;
      // negative b encodes a right shift by -b
      amt          = SHW'(b[WIDTH-1] ? -b : b);

      // one step of the iterative shifter
      if (sh_right) begin
         sh_val = {sh_arith & wrk[WIDTH-1], wrk[WIDTH-1:1]};
         sh_bit = wrk[0];
      end else begin
         sh_val = {wrk[WIDTH-2:0], 1'b0};
         sh_bit = wrk[WIDTH-1];
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               done_nxt = 1'b1;
               case (op)
                  OP_ADD, OP_ADDU: begin
                     sum        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                     result_nxt = sum[WIDTH-1:0];
                     carry_nxt  = sum[WIDTH];
                     low_nxt    = 1'b0;
                     ovf_nxt    = (op == OP_ADD) && (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != a[WIDTH-1]);
                     zero_nxt   = (sum[WIDTH-1:0] == '0);
                     neg_nxt    = (op == OP_ADD) && sum[WIDTH-1];
                  end
                  OP_SUB: begin
                     sum        = {1'b0, a} - {1'b0, b};
                     result_nxt = sum[WIDTH-1:0];
                     carry_nxt  = sum[WIDTH];
                     low_nxt    = 1'b0;
                     ovf_nxt    = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != a[WIDTH-1]);
                     zero_nxt   = (sum[WIDTH-1:0] == '0);
                     neg_nxt    = sum[WIDTH-1];
                  end
                  OP_CMP: begin
                     carry_nxt = 1'b0;
                     low_nxt   = 1'b0;
                     ovf_nxt   = 1'b0;
                     zero_nxt  = (a == b);
                     neg_nxt   = ($signed(b) < $signed(a));
                  end
                  OP_CMPU: begin
                     carry_nxt = 1'b0;
                     low_nxt   = (b < a);
                     ovf_nxt   = 1'b0;
                     zero_nxt  = (a == b);
                     neg_nxt   = 1'b0;
                  end
                  OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                     case (op)
                        OP_AND:  result_nxt = a & b;
                        OP_OR:   result_nxt = a | b;
                        OP_XOR:  result_nxt = a ^ b;
                        default: result_nxt = ~a;
                     endcase
                     carry_nxt = 1'b0;
                     low_nxt   = 1'b0;
                     ovf_nxt   = 1'b0;
                     zero_nxt  = (result_nxt == '0);
                     neg_nxt   = 1'b0;
                  end
                  OP_MOV: begin
                     result_nxt = b;
                  end
                  OP_LSH, OP_ASH: begin
                     if (amt == '0) begin
                        result_nxt = a;
                        carry_nxt  = 1'b0;
                        low_nxt    = 1'b0;
                        ovf_nxt    = 1'b0;
                        zero_nxt   = (a == '0);
                        neg_nxt    = (op == OP_ASH) && a[WIDTH-1];
                     end else begin
                        done_nxt     = 1'b0;
                        busy_nxt     = 1'b1;
                        state_nxt    = S_SHIFT;
                        wrk_nxt      = a;
                        cnt_nxt      = {1'b0, amt};
                        sh_right_nxt = b[WIDTH-1];
                        sh_arith_nxt = (op == OP_ASH);
                     end
                  end
`ifdef ALU_MUL_EN
                  OP_MUL: begin
                     done_nxt  = 1'b0;
                     busy_nxt  = 1'b1;
                     state_nxt = S_MUL;
                     mcand_nxt = a;
                     wrk_nxt   = b;
                     acc_nxt   = '0;
                     cnt_nxt   = CW'(WIDTH);
                  end
`endif
                  default: begin
                     // NOP and undefined opcodes: pulse done, hold result and flags
                  end
               endcase
            end
         end

         S_SHIFT: begin
            wrk_nxt = sh_val;
            cnt_nxt = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = S_IDLE;
               result_nxt = sh_val;
               carry_nxt  = sh_bit;
               low_nxt    = 1'b0;
               ovf_nxt    = 1'b0;
               zero_nxt   = (sh_val == '0);
               neg_nxt    = sh_arith && sh_val[WIDTH-1];
            end
         end

`ifdef ALU_MUL_EN
         S_MUL: begin
            // {acc, wrk} is the running product, shifted right each iteration
            acc_nxt = mac[WIDTH:1];
            wrk_nxt = {mac[0], wrk[WIDTH-1:1]};
            cnt_nxt = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = S_IDLE;
               result_nxt = wrk_nxt;
               carry_nxt  = |acc_nxt;
               low_nxt    = 1'b0;
               ovf_nxt    = 1'b0;
               zero_nxt   = (wrk_nxt == '0);
               neg_nxt    = 1'b0;
            end
         end
`endif

         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // state and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         low      <= 1'b0;
         ovf      <= 1'b0;
         zero     <= 1'b0;
         neg      <= 1'b0;
         wrk      <= '0;
         cnt      <= '0;
         sh_right <= 1'b0;
         sh_arith <= 1'b0;
`ifdef ALU_MUL_EN
         mcand    <= '0;
         acc      <= '0;
`endif
      end else begin
         state    <= state_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         result   <= result_nxt;
         carry    <= carry_nxt;
         low      <= low_nxt;
         ovf      <= ovf_nxt;
         zero     <= zero_nxt;
         neg      <= neg_nxt;
         wrk      <= wrk_nxt;
         cnt      <= cnt_nxt;
         sh_right <= sh_right_nxt;
         sh_arith <= sh_arith_nxt;
`ifdef ALU_MUL_EN
         mcand    <= mcand_nxt;
         acc      <= acc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=16) against a
// transaction-level model that computes each outcome with plain arithmetic.
module tb_alu_seq;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, cin;
   logic [7:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, carry, low, ovf, zero, neg;
   logic [W-1:0]  result;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .result(result),
      .carry(carry), .low(low), .ovf(ovf), .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   // model state: what the outputs must show after each edge
   logic [W-1:0] m_res;
   logic         m_c, m_l, m_f, m_z, m_n, m_busy, m_done;
   int           m_rem;
   // outcome of the op in flight
   logic [W-1:0] p_res;
   logic         p_c, p_l, p_f, p_z, p_n;
   int           p_lat;

   task automatic predict(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci);
      int          s, sv, amt;
      logic [31:0] w;
      logic [W-1:0] ny;
      p_res = m_res; p_c = m_c; p_l = m_l; p_f = m_f; p_z = m_z; p_n = m_n; p_lat = 1;
      case (o)
         8'h05, 8'h06: begin
            s  = int'(x) + int'(y) + int'(ci);
            sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
            p_res = W'(s); p_c = (s > 65535); p_l = 0;
            p_f = (o == 8'h05) && (sv > 32767 || sv < -32768);
            p_n = (o == 8'h05) && p_res[W-1]; p_z = (p_res == 0);
         end
         8'h09: begin
            sv = int'($signed(x)) - int'($signed(y));
            p_res = x - y; p_c = (x < y); p_l = 0;
            p_f = (sv > 32767 || sv < -32768); p_n = p_res[W-1]; p_z = (p_res == 0);
         end
         8'h0C: begin p_c = 0; p_l = 0; p_f = 0; p_z = (x == y); p_n = ($signed(y) < $signed(x)); end
         8'h0B: begin p_c = 0; p_f = 0; p_n = 0; p_z = (x == y); p_l = (y < x); end
         8'h01, 8'h02, 8'h03, 8'h0E: begin
            if (o == 8'h01) p_res = x & y;
            else if (o == 8'h02) p_res = x | y;
            else if (o == 8'h03) p_res = x ^ y;
            else p_res = ~x;
            p_c = 0; p_l = 0; p_f = 0; p_n = 0; p_z = (p_res == 0);
         end
         8'h0D: p_res = y;
         8'h84, 8'h86: begin
            ny  = 16'h0000 - y;
            amt = y[W-1] ? int'(ny) % 16 : int'(y) % 16;
            if (amt == 0) begin
               p_res = x; p_c = 0;
            end else if (!y[W-1]) begin
               w = 32'(x) << amt;
               p_res = w[15:0]; p_c = w[16];
            end else begin
               p_c = x[amt-1];
               p_res = (o == 8'h86) ? W'($signed(x) >>> amt) : (x >> amt);
            end
            p_lat = amt + 1;
            p_l = 0; p_f = 0; p_z = (p_res == 0); p_n = (o == 8'h86) && p_res[W-1];
         end
`ifdef ALU_MUL_EN
         8'h0F: begin
            w = 32'(x) * 32'(y);
            p_res = w[15:0]; p_c = (w[31:16] != 0);
            p_l = 0; p_f = 0; p_n = 0; p_z = (p_res == 0); p_lat = W + 1;
         end
`endif
         default: ;
      endcase
   endtask

   task automatic apply_pending();
      m_res = p_res; m_c = p_c; m_l = p_l; m_f = p_f; m_z = p_z; m_n = p_n;
   endtask

   // transaction-level reference model, advanced at each rising edge
   always @(posedge clk) begin
      if (!rst_n) begin
         m_res = '0; m_c = 0; m_l = 0; m_f = 0; m_z = 0; m_n = 0;
         m_busy = 0; m_done = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
         m_done = 0;
         if (m_rem == 0) begin
            apply_pending(); m_done = 1; m_busy = 0;
         end
      end else begin
         m_done = 0;
         if (start) begin
            predict(op, a, b, cin);
            if (p_lat == 1) begin
               apply_pending(); m_done = 1;
            end else begin
               m_rem = p_lat - 1; m_busy = 1;
            end
         end
      end
   end

   // every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({busy, done, result, carry, low, ovf, zero, neg} !==
             {m_busy, m_done, m_res, m_c, m_l, m_f, m_z, m_n}) begin
            failures++;
            $display("FAIL model_cmp t=%0t actual busy=%b done=%b res=%h clfzn=%b%b%b%b%b required busy=%b done=%b res=%h clfzn=%b%b%b%b%b",
                     $time, busy, done, result, carry, low, ovf, zero, neg,
                     m_busy, m_done, m_res, m_c, m_l, m_f, m_z, m_n);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci);
      @(negedge clk);
      op = o; a = x; b = y; cin = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts busy cycles until the done pulse is visible, bounded
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_done actual=timeout required=done");
      end
   endtask

   logic [7:0] ops [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09,
                            8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h84, 8'h86};

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_state", 32'({busy, done, result, carry, low, ovf, zero, neg}), 32'h0);
      rst_n = 1'b1;

      start_op(8'h05, 16'h7FFF, 16'h0001, 1'b0);
      chk("add_done", 32'(done), 32'h1);
      chk("add_result", 32'(result), 32'h8000);
      chk("add_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b00101);

      start_op(8'h09, 16'h0003, 16'h0005, 1'b0);
      chk("sub_result", 32'(result), 32'hFFFE);
      chk("sub_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b10001);

      start_op(8'h0B, 16'h0005, 16'h0003, 1'b0);
      chk("cmpu_result_holds", 32'(result), 32'hFFFE);
      chk("cmpu_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b01000);

      start_op(8'h86, 16'h8010, 16'hFFFC, 1'b0);
      wait_done(n);
      chk("ash_busy_cycles", 32'(n), 32'd4);
      chk("ash_result", 32'(result), 32'hF801);
      chk("ash_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b00001);

      start_op(8'h84, 16'h8001, 16'h0001, 1'b0);
      wait_done(n);
      chk("lsh1_busy_cycles", 32'(n), 32'd1);
      chk("lsh1_result", 32'(result), 32'h0002);
      chk("lsh1_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b10000);

      // reset in the third busy cycle of a shift by 8
      start_op(8'h84, 16'h1234, 16'h0008, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lsh8_still_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_state", 32'({busy, done, result, carry, low, ovf, zero, neg}), 32'h0);
      rst_n = 1'b1;

      // start pulses while busy are ignored; AND issued in the done cycle
      start_op(8'h84, 16'h00FF, 16'h0003, 1'b0);
      op = 8'h05; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("lsh3_result", 32'(result), 32'h07F8);
      op = 8'h01; a = 16'h00F0; b = 16'h0F00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_and_done", 32'(done), 32'h1);
      chk("b2b_and_result", 32'(result), 32'h0000);
      chk("b2b_and_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b00010);

      start_op(8'h0F, 16'h0100, 16'h0101, 1'b0);
      wait_done(n);
`ifdef ALU_MUL_EN
      chk("mul_busy_cycles", 32'(n), 32'd16);
      chk("mul_result", 32'(result), 32'h0100);
      chk("mul_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b10000);
`else
      chk("mul_undef_busy_cycles", 32'(n), 32'd0);
      chk("mul_undef_result", 32'(result), 32'h0000);
      chk("mul_undef_flags_clfzn", 32'({carry, low, ovf, zero, neg}), 32'b00010);
`endif

      // randomized traffic, including starts while busy and rare resets
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 299) != 0);
         start = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) == 0) op = 8'($urandom);
         else op = ops[$urandom_range(0, 13)];
         a   = W'($urandom);
         cin = 1'($urandom);
         case ($urandom_range(0, 4))
            0:       b = W'($urandom_range(0, 15));
            1:       b = 16'h0000 - W'($urandom_range(0, 15));
            2:       b = a;
            default: b = W'($urandom);
         endcase
      end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
